// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment capture path.
// Patterns are active-low, bit0=a .. bit6=g.
package seg7_pkg;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h18;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seg7_to_hex.sv
// Inverse seven-segment decode.
// Unknown patterns give hex 0 with o_invalid set.
module seg7_to_hex
  import seg7_pkg::*;
(
  input  logic [6:0] i_seg7,
  output logic [3:0] o_hex,
  output logic       o_invalid
);

  always_comb begin
    o_hex     = 4'h0;
    o_invalid = 1'b0;
    unique case (i_seg7)
      SEG_0:   o_hex = 4'h0;
      SEG_1:   o_hex = 4'h1;
      SEG_2:   o_hex = 4'h2;
      SEG_3:   o_hex = 4'h3;
      SEG_4:   o_hex = 4'h4;
      SEG_5:   o_hex = 4'h5;
      SEG_6:   o_hex = 4'h6;
      SEG_7:   o_hex = 4'h7;
      SEG_8:   o_hex = 4'h8;
      SEG_9:   o_hex = 4'h9;
      SEG_A:   o_hex = 4'hA;
      SEG_B:   o_hex = 4'hB;
      SEG_C:   o_hex = 4'hC;
      SEG_D:   o_hex = 4'hD;
      SEG_E:   o_hex = 4'hE;
      SEG_F:   o_hex = 4'hF;
      default: o_invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// Samples a multiplexed 7-seg bus, captures each stable digit
// and publishes a whole frame once every digit has been seen.
module seg7_scan_capture #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            seg7_in,
  input  logic [DIGITS-1:0]     dig_sel,
  output logic [4*DIGITS-1:0]   hex_out,
  output logic                  valid,
  output logic                  err
);

  import seg7_pkg::*;

  localparam int SW = DIGITS + 7;
  localparam logic [SW-1:0] S_RST = {{DIGITS{1'b1}}, SEG_BLANK};
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ARM = CNT_W'(STABLE_CYCLES - 2);

  logic [SW-1:0]         r_s_q;
  logic [SW-1:0]         r_s_prev;
  logic [CNT_W-1:0]      r_cnt;
  logic [DIGITS-1:0]     r_captured;
  logic                  r_err_pend;
  logic [4*DIGITS-1:0]   r_slots;
  logic [4*DIGITS-1:0]   r_hex;
  logic                  r_valid;
  logic                  r_err;

  logic [DIGITS-1:0]     w_sel;
  logic [6:0]            w_seg;
  logic                  w_same;
  logic                  w_digit;
  logic                  w_cap;
  logic [DIGITS-1:0]     w_cap_vec;
  logic [3:0]            w_hex;
  logic                  w_inv;
  logic                  w_cap_err;
  logic                  w_done;
  logic [4*DIGITS-1:0]   w_slots_nxt;

  assign w_sel   = r_s_q[SW-1:7];
  assign w_seg   = r_s_q[6:0];
  assign w_same  = (r_s_q == r_s_prev);
  assign w_digit = $onehot(~w_sel);

  // Capture only on the edge the counter reaches its final value,
  // so a held pattern is taken exactly once.
  assign w_cap     = w_same && (r_cnt == CNT_ARM) && w_digit;
  assign w_cap_vec = w_cap ? ~w_sel : '0;
  assign w_cap_err = w_cap && w_inv;
  assign w_done    = w_cap && (&(r_captured | w_cap_vec));

  seg7_to_hex u_dec (
    .i_seg7    (w_seg),
    .o_hex     (w_hex),
    .o_invalid (w_inv)
  );

  always_comb begin
    w_slots_nxt = r_slots;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_cap_vec[i] && !w_inv) begin
        w_slots_nxt[4*i +: 4] = w_hex;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s_q      <= S_RST;
      r_s_prev   <= S_RST;
      r_cnt      <= '0;
      r_captured <= '0;
      r_err_pend <= 1'b0;
      r_slots    <= '0;
      r_hex      <= '0;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_s_q    <= {dig_sel, seg7_in};
      r_s_prev <= r_s_q;
      if (!w_same) begin
        r_cnt <= '0;
      end else if (r_cnt < CNT_MAX) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      r_slots <= w_slots_nxt;
      r_valid <= 1'b0;
      if (w_done) begin
        r_hex      <= w_slots_nxt;
        r_err      <= r_err_pend | w_cap_err;
        r_valid    <= 1'b1;
        r_captured <= '0;
        r_err_pend <= 1'b0;
      end else begin
        r_captured <= r_captured | w_cap_vec;
        if (w_cap_err) begin
          r_err_pend <= 1'b1;
        end
      end
    end
  end

  assign hex_out = r_hex;
  assign valid   = r_valid;
  assign err     = r_err;

endmodule
